// File: rtl/nanorv32_load_wb.sv
// rtl/nanorv32_load_wb.sv - load data alignment and register-file second write port
//
// Purpose:
//   Tracks a single outstanding load. It captures the request, waits for the
//   memory read data, aligns and extends that data, then writes it back through
//   the register file's second write port. While the load is pending it raises
//   a RAW hazard stall against the decode read selects.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       load request handshake
//   req_rd, req_size,
//   req_unsigned, req_addr_lo   destination, size (0 byte, 1 half, 2/3 word),
//                               zero-extend flag, address bits [1:0]
//   mem_rvalid, mem_rdata       raw read data from the bus
//   flush                       abandon the pending load
//   sel_porta, sel_portb        decode read selects used for hazard detection
//   stall                       RAW hazard on the pending load
//   sel_rd2, rd2, write_rd2     register-file second write port
//   fwd_valid, fwd_data         bypass outputs (only with NANORV32_LOAD_WB_BYPASS_EN)
//
// Configuration:
//   NANORV32_LOAD_WB_BYPASS_EN  adds the forwarding outputs and drops the stall
//                               in the WRITE state, since decode takes fwd_data.

module nanorv32_load_wb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [1:0]  req_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [4:0]  sel_porta,
    input  logic [4:0]  sel_portb,
    output logic        stall,
`ifdef NANORV32_LOAD_WB_BYPASS_EN
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
`endif
    output logic [4:0]  sel_rd2,
    output logic [31:0] rd2,
    output logic        write_rd2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  cap_rd;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_addr_lo;

    logic        accept;
    logic        load_done;
    logic        rd_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] aligned;

    // Alignment uses the captured fields; mem_rdata is only sampled in WAIT.
    always_comb begin
        byte_sel = 8'h00;
        case (cap_addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = cap_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cap_size)
            2'd0:    aligned = {{24{~cap_unsigned & byte_sel[7]}}, byte_sel};
            2'd1:    aligned = {{16{~cap_unsigned & half_sel[15]}}, half_sel};
            default: aligned = mem_rdata;
        endcase
    end

    assign rd_hit = (cap_rd != 5'd0) && ((sel_porta == cap_rd) || (sel_portb == cap_rd));

    // Next state and outputs. Flush overrides every other input.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        write_rd2  = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~flush;
                if (req_valid) state_next = WAIT;
            end
            WAIT: begin
                stall = rd_hit & ~flush;
                if (mem_rvalid) state_next = WRITE;
            end
            WRITE: begin
                req_ready  = ~flush;
                write_rd2  = (cap_rd != 5'd0) & ~flush;
`ifdef NANORV32_LOAD_WB_BYPASS_EN
                stall      = 1'b0;
`else
                stall      = rd_hit & ~flush;
`endif
                state_next = req_valid ? WAIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign accept    = req_ready & req_valid;
    assign load_done = (state == WAIT) & mem_rvalid & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Captured request and write-port registers. sel_rd2/rd2 only change when
    // a load completes, so they hold their value outside WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rd       <= 5'd0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_addr_lo  <= 2'd0;
            sel_rd2      <= 5'd0;
            rd2          <= 32'd0;
        end else begin
            if (accept) begin
                cap_rd       <= req_rd;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_addr_lo  <= req_addr_lo;
            end
            if (load_done) begin
                rd2     <= aligned;
                sel_rd2 <= cap_rd;
            end
        end
    end

`ifdef NANORV32_LOAD_WB_BYPASS_EN
    assign fwd_valid = write_rd2;
    assign fwd_data  = rd2;
`endif

endmodule
